// File: rtl/sdr_sync_ctrl.sv
// sdr_sync_ctrl: arms on request, aligns the sample counter to the next 1PPS edge
// and supervises the PPS period. Optional period/lock check: SYNC_PERIOD_CHECK_EN.
module sdr_sync_ctrl #(
  parameter int CNT_W      = 32,
  parameter int NOM_PERIOD = 30720000,
  parameter int TOL        = 16,
  parameter int TIMEOUT    = 32000000,
  parameter int LOCK_N     = 3
) (
  input  logic             CLK,
  input  logic             RSET,
  input  logic             ARM,
  input  logic             DISARM,
  input  logic             SIG,
  input  logic [CNT_W-1:0] LOAD_VAL,
  output logic             CNT_EN,
  output logic             CNT_LD,
  output logic [CNT_W-1:0] CNT_D,
  output logic             U_D,
  output logic             DIS_TRIG,
  output logic             LOCKED,
  output logic             ERR,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] PERIOD
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    LOAD      = 3'd2,
    RUN       = 3'd3,
    ERROR     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT <= NOM_PERIOD + TOL) begin : g_bad_timeout
    $error("TIMEOUT must exceed NOM_PERIOD+TOL");
  end
  if (LOCK_N < 1) begin : g_bad_lock_n
    $error("LOCK_N must be at least 1");
  end

  state_t           state;
  state_t           nxt;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pps_edge;
  logic             edge_run;
  logic             period_ok;

  assign pps_edge = sync_q[1] & ~sync_q[2];
  assign edge_run = (state == RUN) && pps_edge;
  // One counter serves as the WAIT_EDGE timer and the RUN period counter; it never wraps.
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign STATE    = state;
  assign U_D      = 1'b1;

`ifdef SYNC_PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0] PER_HI = CNT_W'(NOM_PERIOD + TOL);
  localparam int LK_W = $clog2(LOCK_N + 1);
  logic [LK_W-1:0] lock_cnt;
  assign period_ok = (cnt >= PER_LO) && (cnt <= PER_HI);
`else
  assign period_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: nxt gets a value on every path before the case, so no latch is inferred.
    nxt = IDLE;
    case (state)
      IDLE:      nxt = IDLE;
      WAIT_EDGE: begin
        if (pps_edge)            nxt = LOAD;
        else if (cnt == TO_LAST) nxt = ERROR;
        else                     nxt = WAIT_EDGE;
      end
      LOAD:      nxt = RUN;
      RUN: begin
        // An edge wins over a coincident timeout.
        if (pps_edge)            nxt = period_ok ? RUN : ERROR;
        else if (cnt >= TO_LAST) nxt = ERROR;
        else                     nxt = RUN;
      end
      ERROR:     nxt = ERROR;
      default:   nxt = IDLE;
    endcase
    if (ARM)    nxt = WAIT_EDGE;
    if (DISARM) nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RSET) begin
      sync_q   <= '0;
      state    <= IDLE;
      cnt      <= '0;
      CNT_EN   <= 1'b0;
      CNT_LD   <= 1'b0;
      CNT_D    <= '0;
      DIS_TRIG <= 1'b1;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      PERIOD   <= '0;
`ifdef SYNC_PERIOD_CHECK_EN
      lock_cnt <= '0;
`endif
    end else begin
      sync_q   <= {sync_q[1:0], SIG};
      state    <= nxt;
      CNT_LD   <= (nxt == LOAD);
      CNT_EN   <= (nxt == RUN);
      DIS_TRIG <= (nxt != RUN);
      ERR      <= (nxt == ERROR);

      if (ARM && !DISARM) CNT_D <= LOAD_VAL;

      case (nxt)
        WAIT_EDGE: cnt <= (state == WAIT_EDGE && !ARM) ? cnt_inc : '0;
        LOAD:      cnt <= CNT_W'(1);
        RUN:       cnt <= edge_run ? CNT_W'(1) : cnt_inc;
        default:   cnt <= '0;
      endcase

      if (edge_run && !ARM && !DISARM) PERIOD <= cnt;

`ifdef SYNC_PERIOD_CHECK_EN
      // Staying in RUN on an edge implies the period was in tolerance.
      if (nxt != RUN) begin
        lock_cnt <= '0;
        LOCKED   <= 1'b0;
      end else if (edge_run) begin
        if (lock_cnt != LK_W'(LOCK_N)) lock_cnt <= lock_cnt + LK_W'(1);
        if (lock_cnt >= LK_W'(LOCK_N - 1)) LOCKED <= 1'b1;
      end
`else
      LOCKED <= (nxt == RUN);
`endif
    end
  end

endmodule

// File: tb/tb_sdr_sync_ctrl.sv
// tb_sdr_sync_ctrl: directed vectors for sdr_sync_ctrl (NOM_PERIOD=100, TOL=2,
// TIMEOUT=150, LOCK_N=3, CNT_W=16); expectations follow SYNC_PERIOD_CHECK_EN.
module tb_sdr_sync_ctrl;

`ifdef SYNC_PERIOD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        CLK;
  logic        RSET;
  logic        ARM;
  logic        DISARM;
  logic        SIG;
  logic [15:0] LOAD_VAL;
  logic        CNT_EN;
  logic        CNT_LD;
  logic [15:0] CNT_D;
  logic        U_D;
  logic        DIS_TRIG;
  logic        LOCKED;
  logic        ERR;
  logic [2:0]  STATE;
  logic [15:0] PERIOD;

  int n_vec  = 0;
  int n_miss = 0;

  sdr_sync_ctrl #(
    .CNT_W(16), .NOM_PERIOD(100), .TOL(2), .TIMEOUT(150), .LOCK_N(3)
  ) dut (
    .CLK(CLK), .RSET(RSET), .ARM(ARM), .DISARM(DISARM), .SIG(SIG),
    .LOAD_VAL(LOAD_VAL), .CNT_EN(CNT_EN), .CNT_LD(CNT_LD), .CNT_D(CNT_D),
    .U_D(U_D), .DIS_TRIG(DIS_TRIG), .LOCKED(LOCKED), .ERR(ERR),
    .STATE(STATE), .PERIOD(PERIOD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Hold SIG low for n cycles, then raise it (rising edge n cycles after the call).
  task automatic gap(input int n);
    SIG = 1'b0;
    tick(n);
    SIG = 1'b1;
  endtask

  task automatic arm(input logic [15:0] val);
    ARM      = 1'b1;
    LOAD_VAL = val;
    tick();
    ARM      = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    check({p, "_state"}, STATE,    3'd0);
    check({p, "_en"},    CNT_EN,   1'b0);
    check({p, "_ld"},    CNT_LD,   1'b0);
    check({p, "_d"},     CNT_D,    16'h0);
    check({p, "_ud"},    U_D,      1'b1);
    check({p, "_dis"},   DIS_TRIG, 1'b1);
    check({p, "_lock"},  LOCKED,   1'b0);
    check({p, "_err"},   ERR,      1'b0);
    check({p, "_per"},   PERIOD,   16'h0);
  endtask

  initial begin
    RSET = 1'b1; ARM = 1'b0; DISARM = 1'b0; SIG = 1'b0; LOAD_VAL = '0;
    tick(2);
    chk_reset("rst");
    RSET = 1'b0;

    // Alignment: rising SIG -> LOAD 3 cycles later, RUN the cycle after.
    arm(16'h1234);
    check("arm_state", STATE, 3'd1);
    check("arm_d",     CNT_D, 16'h1234);
    tick(18);
    SIG = 1'b1;
    tick(2);
    check("pre_ld_state", STATE, 3'd1);
    tick();
    check("ld_pulse", CNT_LD, 1'b1);
    check("ld_data",  CNT_D,  16'h1234);
    check("ld_en",    CNT_EN, 1'b0);
    check("ld_state", STATE,  3'd2);
    tick();
    check("run_ld",    CNT_LD,   1'b0);
    check("run_en",    CNT_EN,   1'b1);
    check("run_dis",   DIS_TRIG, 1'b0);
    check("run_state", STATE,    3'd3);
    check("run_lock",  LOCKED,   !CHK);

    // Three nominal periods: PERIOD=100 each time, lock on the third.
    gap(96);
    tick(3);
    check("p1_per",  PERIOD, 16'd100);
    check("p1_lock", LOCKED, !CHK);
    gap(97);
    tick(3);
    check("p2_per",  PERIOD, 16'd100);
    check("p2_lock", LOCKED, !CHK);
    gap(97);
    tick(3);
    check("p3_per",  PERIOD, 16'd100);
    check("p3_lock", LOCKED, 1'b1);
    check("p3_err",  ERR,    1'b0);

    // Late edge (105 cycles).
    gap(102);
    tick(3);
    check("late_per",   PERIOD, 16'd105);
    check("late_state", STATE,  CHK ? 3'd4 : 3'd3);
    check("late_en",    CNT_EN, !CHK);
    check("late_err",   ERR,    CHK);
    check("late_lock",  LOCKED, !CHK);
    tick(10);
    check("hold_err",   ERR,    CHK);
    check("hold_state", STATE,  CHK ? 3'd4 : 3'd3);

    // WAIT_EDGE timeout: SIG stays high, so no new edge.
    arm(16'h00AB);
    check("rearm_state", STATE, 3'd1);
    check("rearm_err",   ERR,   1'b0);
    check("rearm_d",     CNT_D, 16'h00AB);
    check("rearm_lock",  LOCKED, 1'b0);
    tick(149);
    check("wto_149", STATE, 3'd1);
    tick();
    check("wto_150", STATE, 3'd4);
    check("wto_err", ERR,   1'b1);

    // RUN timeout: ERROR 150 cycles after the last edge.
    arm(16'h0001);
    gap(5);
    tick(4);
    check("rto_run", STATE, 3'd3);
    tick(147);
    check("rto_149", STATE, 3'd3);
    tick();
    check("rto_150", STATE,  3'd4);
    check("rto_err", ERR,    1'b1);
    check("rto_en",  CNT_EN, 1'b0);

    // ARM and DISARM together in RUN: DISARM wins.
    arm(16'h0002);
    gap(5);
    tick(4);
    check("ad_run", STATE, 3'd3);
    ARM = 1'b1; DISARM = 1'b1;
    tick();
    ARM = 1'b0; DISARM = 1'b0;
    check("ad_state", STATE,    3'd0);
    check("ad_en",    CNT_EN,   1'b0);
    check("ad_dis",   DIS_TRIG, 1'b1);
    check("ad_lock",  LOCKED,   1'b0);
    check("ad_err",   ERR,      1'b0);

    // Reset in RUN while a SIG edge sits in the synchronizer.
    arm(16'h5A5A);
    gap(5);
    tick(4);
    check("rr_run", STATE, 3'd3);
    SIG = 1'b0;
    tick();
    SIG = 1'b1;
    tick();
    RSET = 1'b1;
    tick();
    RSET = 1'b0;
    chk_reset("rr");
    tick(4);
    check("rr_no_ld",  CNT_LD, 1'b0);
    check("rr_idle",   STATE,  3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
